// File: rtl/row_loader.sv
// rtl/row_loader.sv - pops 64-bit words from a FIFO into 4-word rows, handshaking each row with a consumer
//
// Purpose: on a start pulse, loads ROWS rows of four 64-bit words from a
// source FIFO into a row register file. Each full row is announced with a
// one-cycle full_row pulse. The next row is fetched only after the consumer
// returns row_ack. A done pulse follows the last acknowledged row.
//
// Parameters:
//   ROWS         rows per frame (1..255)
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   start        one-cycle frame start (ignored unless idle)
//   fifo_empty   source FIFO has no word
//   fifo_rd_en   pop request; the word arrives on fifo_rd_data next cycle
//   fifo_rd_data popped FIFO word
//   wr_en        row register file write strobe
//   wr_addr      word slot 0..3 within the row
//   wr_data      word being written (holds its last value when idle)
//   full_row     one-cycle pulse once a 4-word row is stored
//   row_ack      consumer finished with the current row
//   busy         frame in progress
//   done         one-cycle pulse after the last row is acknowledged
//   stall_cnt    (only with ROW_LOADER_STALL_CNT_EN) saturating count of
//                fetch cycles starved by an empty FIFO
//
// Optional feature macro: ROW_LOADER_STALL_CNT_EN
module row_loader #(
    parameter int ROWS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    input  logic [63:0] fifo_rd_data,
    output logic        wr_en,
    output logic [1:0]  wr_addr,
    output logic [63:0] wr_data,
    output logic        full_row,
    input  logic        row_ack,
    output logic        busy,
    output logic        done
`ifdef ROW_LOADER_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_NOTIFY,
        S_WAIT_ACK
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_issued;
    logic [2:0]  r_written;
    logic [7:0]  r_row_cnt;
    logic        r_rd_pend;
    logic [63:0] r_wr_data;
    logic        r_done;

    logic        w_pop;
    logic        w_start_ok;
    logic        w_clr_row;
    logic        w_finish;
    logic        w_last_row;

    // A pop is only requested while fewer than four words of this row have
    // been issued, so a row can never receive more than four writes.
    assign w_pop      = (r_state == S_FETCH) && !fifo_empty && (r_issued < 3'd4);
    // Widened by one bit so ROWS = 255 compares without overflow.
    assign w_last_row = (({1'b0, r_row_cnt} + 9'd1) == 9'(ROWS));

    always_comb begin
        w_next     = r_state;
        w_start_ok = 1'b0;
        w_clr_row  = 1'b0;
        w_finish   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next     = S_FETCH;
                    w_start_ok = 1'b1;
                end
            end
            S_FETCH: begin
                // Leave once the fourth word of the row is being written.
                if (r_rd_pend && (r_written == 3'd3)) begin
                    w_next = S_NOTIFY;
                end
            end
            S_NOTIFY: begin
                w_next = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (row_ack) begin
                    if (w_last_row) begin
                        w_next   = S_IDLE;
                        w_finish = 1'b1;
                    end else begin
                        w_next    = S_FETCH;
                        w_clr_row = 1'b1;
                    end
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Clearing r_rd_pend on reset drops the word of any read still in
    // flight, so an abandoned frame never produces a stray write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_issued  <= 3'd0;
            r_written <= 3'd0;
            r_row_cnt <= 8'd0;
            r_rd_pend <= 1'b0;
            r_wr_data <= 64'd0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_rd_pend <= w_pop;
            r_done    <= w_finish;
            if (w_start_ok || w_clr_row) begin
                r_issued  <= 3'd0;
                r_written <= 3'd0;
            end else begin
                if (w_pop) begin
                    r_issued <= r_issued + 3'd1;
                end
                if (r_rd_pend) begin
                    r_written <= r_written + 3'd1;
                end
            end
            if (w_start_ok) begin
                r_row_cnt <= 8'd0;
            end else if ((r_state == S_WAIT_ACK) && row_ack) begin
                r_row_cnt <= r_row_cnt + 8'd1;
            end
            if (r_rd_pend) begin
                r_wr_data <= fifo_rd_data;
            end
        end
    end

    // The FIFO word is forwarded in the cycle it arrives; the register keeps
    // the last written word visible while no write is in progress.
    assign fifo_rd_en = w_pop;
    assign wr_en      = r_rd_pend;
    assign wr_addr    = r_written[1:0];
    assign wr_data    = r_rd_pend ? fifo_rd_data : r_wr_data;
    assign full_row   = (r_state == S_NOTIFY);
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;

`ifdef ROW_LOADER_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 16'd0;
        end else if (w_start_ok) begin
            r_stall_cnt <= 16'd0;
        end else if ((r_state == S_FETCH) && (r_issued < 3'd4) && fifo_empty
                     && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_row_loader.sv
// tb/tb_row_loader.sv - scoreboard testbench for row_loader
module tb_row_loader;

    localparam int NR = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [63:0] fifo_rd_data = 64'd0;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [63:0] wr_data;
    logic        full_row;
    logic        row_ack = 1'b0;
    logic        busy;
    logic        done;
`ifdef ROW_LOADER_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    row_loader #(.ROWS(NR)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .full_row     (full_row),
        .row_ack      (row_ack),
        .busy         (busy),
        .done         (done)
`ifdef ROW_LOADER_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  a;
        logic [63:0] d;
    } wr_t;

    typedef struct {
        string       nm;
        logic [63:0] act;
        logic [63:0] exp;
    } chk_t;

    int          compared = 0;
    int          mismatched = 0;
    logic [63:0] fifo_q[$];
    logic [63:0] pend_q[$];
    wr_t         exp_q[$];
    chk_t        chk_q[$];
    int          wcyc[$];

    int cyc = 0;
    int pop_cnt = 0;
    int writes_frame = 0;
    int acks_frame = 0;
    bit waiting = 1'b0;
    bit frame_on = 1'b0;
    bit exp_full = 1'b0;
    bit exp_done = 1'b0;

    bit stall_mode = 1'b0;
    int stall_left = 0;
    int stall_base = 0;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: the only process that compares and owns the model state.
    always @(negedge clk) begin
        wr_t e;
        bit  nfull;
        bit  ndone;
        cyc++;
        while (chk_q.size() > 0) begin
            chk_t c;
            c = chk_q.pop_front();
            cmp(c.nm, c.act, c.exp);
        end
        if (rst) begin
            cmp("rst_fifo_rd_en", 64'(fifo_rd_en), 64'd0);
            cmp("rst_wr_en", 64'(wr_en), 64'd0);
            cmp("rst_wr_addr", 64'(wr_addr), 64'd0);
            cmp("rst_wr_data", wr_data, 64'd0);
            cmp("rst_full_row", 64'(full_row), 64'd0);
            cmp("rst_busy", 64'(busy), 64'd0);
            cmp("rst_done", 64'(done), 64'd0);
            fifo_q.delete();
            pend_q.delete();
            exp_q.delete();
            waiting      = 1'b0;
            frame_on     = 1'b0;
            exp_full     = 1'b0;
            exp_done     = 1'b0;
            writes_frame = 0;
            acks_frame   = 0;
        end else begin
            nfull = 1'b0;
            ndone = 1'b0;
            cmp("busy", 64'(busy), 64'(frame_on));
            if (done || exp_done) cmp("done", 64'(done), 64'(exp_done));
            if (full_row || exp_full) cmp("full_row", 64'(full_row), 64'(exp_full));
            if (waiting) cmp("wait_quiet", {62'd0, fifo_rd_en, wr_en}, 64'd0);
            if (fifo_rd_en && fifo_empty) cmp("pop_when_empty", 64'd1, 64'd0);
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    cmp("unexpected_write", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    cmp("wr_addr", 64'(wr_addr), 64'(e.a));
                    cmp("wr_data", wr_data, e.d);
                end
                wcyc.push_back(cyc);
                writes_frame++;
                if (writes_frame % 4 == 0) nfull = 1'b1;
            end
            if (fifo_rd_en) begin
                pop_cnt++;
                if (fifo_q.size() == 0) cmp("pop_underflow", 64'd1, 64'd0);
                else pend_q.push_back(fifo_q.pop_front());
            end
            if (start && !frame_on) begin
                frame_on     = 1'b1;
                writes_frame = 0;
                acks_frame   = 0;
            end
            if (waiting && row_ack && !exp_full) begin
                waiting = 1'b0;
                acks_frame++;
                if (acks_frame == NR) begin
                    ndone    = 1'b1;
                    frame_on = 1'b0;
                end
            end
            if (exp_full) waiting = 1'b1;
            exp_full = nfull;
            exp_done = ndone;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        start   = 1'b0;
        row_ack = 1'b0;
        if (pend_q.size() > 0) fifo_rd_data = pend_q.pop_front();
        else fifo_rd_data = {$urandom, $urandom};
        fifo_empty = (fifo_q.size() == 0) || (stall_mode && ($urandom_range(0, 3) == 0));
        if (stall_left > 0 && (pop_cnt - stall_base) >= 2) begin
            fifo_empty = 1'b1;
            stall_left--;
        end
    endtask

    // Reference model: words leave in FIFO order, landing in slot (index mod 4).
    task automatic push_frame(input bit fixed);
        for (int i = 0; i < 4 * NR; i++) begin
            logic [63:0] d;
            d = (fixed && i < 4) ? 64'(8'hA0 + i) : {$urandom, $urandom};
            fifo_q.push_back(d);
            exp_q.push_back('{a: 2'(i % 4), d: d});
        end
    endtask

    task automatic run_frame(input int amin, input int amax, input bit spur);
        int cd;
        bit seen;
        int budget;
        seen   = 1'b0;
        cd     = 0;
        budget = 600;
        start  = 1'b1;
        tick();
        while (frame_on && budget > 0) begin
            if (waiting) begin
                if (!seen) begin
                    seen = 1'b1;
                    cd   = $urandom_range(amin, amax);
                end
                if (cd == 0) begin
                    row_ack = 1'b1;
                    seen    = 1'b0;
                end else begin
                    cd--;
                end
            end else if (spur && writes_frame < 4 * NR && $urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 1) == 1) start = 1'b1;
                else row_ack = 1'b1;
            end
            tick();
            budget--;
        end
        if (budget == 0) chk_q.push_back('{nm: "frame_timeout", act: 64'd0, exp: 64'd1});
        tick();
        tick();
    endtask

    initial begin
        int b;
        int budget;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Uninterrupted frame with immediate acks: four consecutive writes per row.
        b = wcyc.size();
        push_frame(1'b0);
        run_frame(0, 0, 1'b0);
        if (wcyc.size() >= b + 8) begin
            for (int r = 0; r < NR; r++)
                for (int k = 0; k < 3; k++)
                    chk_q.push_back('{nm: "row_contig",
                                      act: 64'(wcyc[b + 4*r + k + 1] - wcyc[b + 4*r + k]),
                                      exp: 64'd1});
        end else begin
            chk_q.push_back('{nm: "row_write_count", act: 64'(wcyc.size() - b), exp: 64'd8});
        end

        // FIFO runs dry for 3 cycles after the second pop.
        b          = wcyc.size();
        stall_base = pop_cnt;
        stall_left = 3;
        push_frame(1'b1);
        run_frame(0, 0, 1'b0);
        if (wcyc.size() >= b + 4) begin
            chk_q.push_back('{nm: "stall_gap01", act: 64'(wcyc[b+1] - wcyc[b]), exp: 64'd1});
            chk_q.push_back('{nm: "stall_gap12", act: 64'(wcyc[b+2] - wcyc[b+1]), exp: 64'd4});
            chk_q.push_back('{nm: "stall_gap23", act: 64'(wcyc[b+3] - wcyc[b+2]), exp: 64'd1});
        end else begin
            chk_q.push_back('{nm: "stall_write_count", act: 64'(wcyc.size() - b), exp: 64'd4});
        end
`ifdef ROW_LOADER_STALL_CNT_EN
        chk_q.push_back('{nm: "stall_cnt", act: 64'(stall_cnt), exp: 64'd3});
`endif

        // Ack withheld for 10 cycles; the monitor checks the loader stays quiet.
        push_frame(1'b0);
        run_frame(10, 10, 1'b0);

        // Randomized frames with FIFO stalls, ack delays and ignored start/ack pulses.
        for (int f = 0; f < 12; f++) begin
            stall_mode = ($urandom_range(0, 1) == 1);
            push_frame(1'b0);
            run_frame(0, 4, 1'b1);
        end
        stall_mode = 1'b0;

        // Reset in the cycle after the second pop abandons the frame.
        stall_base = pop_cnt;
        push_frame(1'b0);
        start = 1'b1;
        tick();
        budget = 50;
        while ((pop_cnt - stall_base) < 2 && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) chk_q.push_back('{nm: "rst_pop_timeout", act: 64'd0, exp: 64'd1});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        b = wcyc.size();
        push_frame(1'b0);
        run_frame(0, 2, 1'b0);
        chk_q.push_back('{nm: "post_rst_writes", act: 64'(wcyc.size() - b), exp: 64'(4 * NR)});

        chk_q.push_back('{nm: "exp_drained", act: 64'(exp_q.size()), exp: 64'd0});
        chk_q.push_back('{nm: "fifo_drained", act: 64'(fifo_q.size()), exp: 64'd0});
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/row_loader.md
ROW_LOADER -- requirements
Module: row_loader

Interface
REQ-001 SHALL have parameter ROWS, default 8, meaning rows loaded per frame (1..255).
REQ-002 SHALL have clk  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have start  input  1  one-cycle pulse beginning a frame of ROWS rows.
REQ-005 SHALL have fifo_empty  input  1  source FIFO has no word.
REQ-006 SHALL have fifo_rd_en  output  1  pop request to FIFO; data returned next cycle.
REQ-007 SHALL have fifo_rd_data  input  64  FIFO word, valid the cycle after fifo_rd_en.
REQ-008 SHALL have wr_en  output  1  write strobe to row register file.
REQ-009 SHALL have wr_addr  output  2  word slot 0..3 within the row.
REQ-010 SHALL have wr_data  output  64  word to write.
REQ-011 SHALL have full_row  output  1  one-cycle pulse: a complete 4-word row is stored.
REQ-012 SHALL have row_ack  input  1  consumer has finished streaming the current row.
REQ-013 SHALL have busy  output  1  high from accepted start until frame done.
REQ-014 SHALL have done  output  1  one-cycle pulse after the last row is acknowledged.

Function
REQ-015 SHALL implement states IDLE, FETCH, NOTIFY, WAIT_ACK.
REQ-016 IDLE: start -> FETCH, clear issue count, write count and row count; busy=1 from next cycle.
REQ-017 FETCH: fifo_rd_en = !fifo_empty && issued<4 (combinational); issued increments per pop.
REQ-018 Cycle after each pop: wr_en=1, wr_data=fifo_rd_data, wr_addr=written[1:0]; written increments.
REQ-019 Back-to-back pops SHALL sustain one word per cycle; a full row takes 4 cycles with no empty gaps.
REQ-020 fifo_empty mid-row SHALL stall popping only; no write issued for a cycle without a preceding pop.
REQ-021 After 4th write, next cycle SHALL be NOTIFY: full_row=1 exactly one cycle, then WAIT_ACK.
REQ-022 WAIT_ACK: no FIFO pops; on row_ack, row count increments; if count==ROWS -> IDLE with done pulse, else -> FETCH with issue/write counts cleared.
REQ-023 row_ack outside WAIT_ACK SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-024 row_ack and full_row in same cycle: ack ignored (row not yet in WAIT_ACK).
REQ-025 wr_addr SHALL wrap 3 -> 0 only at row boundary; never exceeds 4 writes per row.
REQ-026 wr_data SHALL hold its last value when wr_en=0.

Reset
REQ-027 rst SHALL force state IDLE, all counters 0, fifo_rd_en=0, wr_en=0, wr_addr=0, wr_data=0, full_row=0, busy=0, done=0.
REQ-028 rst mid-frame SHALL abandon the frame; a pending FIFO read's returned data SHALL NOT be written.
REQ-029 After rst release, first action SHALL require a new start.

Configuration
REQ-030 With ROW_LOADER_STALL_CNT_EN defined, SHALL add output stall_cnt (16 bit): counts FETCH cycles with issued<4 and fifo_empty=1, cleared on start and rst, saturates at 0xFFFF.
REQ-031 Without ROW_LOADER_STALL_CNT_EN, stall_cnt port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-032 ROWS=2, FIFO always non-empty, start, immediate row_ack -> wr_addr 0,1,2,3 on 4 consecutive cycles, full_row one cycle later, second row same, done one cycle after second row_ack.
REQ-033 FIFO words 0xA0..0xA3, empty asserted 3 cycles after 2nd pop -> writes 0xA0,0xA1 then 3 idle cycles then 0xA2,0xA3 at addr 2,3; stall_cnt=3 when macro defined.
REQ-034 Withhold row_ack 10 cycles after full_row -> fifo_rd_en stays 0 and wr_en stays 0 for all 10 cycles.
REQ-035 start pulse while busy, row_ack pulse during FETCH -> no restart, row count unchanged.
REQ-036 rst asserted the cycle after 2nd pop -> next cycle wr_en=0, busy=0; new start reloads from wr_addr 0.
